demo_top: RTL and testbench
===========================

Name: demo_top

Overview:
- Board-level demo top for the 50 MHz FPGA board.
- A periodic tick generator drives a byte counter.
- Each tick, the counter value is sent out on an 8N1 UART transmitter.
- An 8N1 UART receiver decodes the serial input and shows the last received byte on the LEDs; a heartbeat LED toggles every tick.
- In system test, uart_tx_path is looped back to uart_rx_path, so the LEDs echo the transmitted counter.

Parameters:
- TICK_CYCLES, 25_000_000, clk_50m cycles per tick (0.5 s). When macro `__SIM_CLK_DIV__` is defined, the effective value is 5_000.
- BAUD_DIV, 434, clk_50m cycles per UART bit (115200 baud). When `__SIM_CLK_DIV__` is defined, the effective value is 16.

Ports:
- clk_50m  input  1  system clock, 50 MHz, sole clock.
- reset_n  input  1  asynchronous, active-high reset (1 = reset, despite the name).
- led  output  6  led[5] is the heartbeat; led[4:0] is the last valid received byte, bits [4:0]; active-high.
- uart_tx_path  output  1  UART TX line, idle high.
- uart_rx_path  input  1  UART RX line, idle high, asynchronous to clk_50m.

Behaviour:
- Reset (reset_n=1, asynchronous):
  - tick counter = 0, tx_count = 0x00, rx_data = 0x00, heartbeat = 0.
  - TX FSM = IDLE, uart_tx_path = 1, RX FSM = IDLE, synchronizer flops = 1.
  - led = 6'b000000.
  - Reset asserted mid-frame aborts the frame; the TX line returns high immediately.
- Tick generator:
  - Counter runs 0..TICK_CYCLES-1 and wraps.
  - tick is a one-cycle pulse when counter == TICK_CYCLES-1.
  - The first tick occurs TICK_CYCLES cycles after reset release.
- On each tick:
  - heartbeat toggles.
  - If the TX FSM is IDLE, tx_count is loaded into the TX shift register and transmission starts on the next cycle.
  - tx_count increments mod 256 on every tick, whether or not the byte was sent; a busy TX drops that value silently.
- UART TX FSM, states IDLE, START, DATA, STOP:
  - Each state lasts BAUD_DIV cycles; the bit counter covers 0..7 in DATA.
  - Frame order: start bit = 0, then data LSB first, then stop bit = 1, then IDLE.
  - Total frame length is 10*BAUD_DIV cycles.
- UART RX:
  - Two-flop synchronizer on uart_rx_path.
  - FSM states IDLE, START, DATA, STOP.
  - IDLE: a falling edge (synchronized 1→0) enters START.
  - START: at BAUD_DIV/2 the line is resampled. If still 0, enter DATA; if 1, the start is false and the FSM returns to IDLE.
  - DATA: samples are taken every BAUD_DIV cycles at bit centres, shifted LSB first.
  - STOP: the line is sampled at the stop-bit centre. If 1, rx_data is updated and a one-cycle rx_valid pulse is generated. If 0 (framing error), the byte is discarded and rx_data keeps its old value.
  - In both cases the FSM returns to IDLE immediately after the stop sample. A following start edge is accepted from then on.
- Loopback latency:
  - TX start edge to rx_valid is about 2 + 9.5*BAUD_DIV cycles.
  - led[4:0] updates on the cycle after rx_valid.
- LEDs are registered outputs: led = {heartbeat, rx_data[4:0]}.
- Counters use the minimum width that holds TICK_CYCLES-1 and BAUD_DIV-1. No other arithmetic.

Decomposition:
- Package demo_pkg holds:
  - TICK_CYCLES and BAUD_DIV, selected by `ifdef __SIM_CLK_DIV__`;
  - the UART state enum typedef {IDLE, START, DATA, STOP}, shared by TX and RX.
- One natural sub-module: uart_8n1, containing the TX and RX FSMs, the synchronizer, the tx_start/tx_byte/tx_busy interface and the rx_data/rx_valid interface.
- Tick generator, counter and LED registers remain in demo_top.

Test Plan (`__SIM_CLK_DIV__` defined, TX looped back to RX):
1. Hold reset_n=1 for 100 cycles, then release. Required: led=000000 and uart_tx_path=1 throughout reset; the first tick occurs at cycle 5000 after release.
2. First frame. Required: uart_tx_path falls 1 cycle after the first tick and carries 0x00, i.e. 0 then eight 0s then 1, each bit lasting 16 cycles. About 154 cycles after the start edge, rx_valid fires and led = 6'b100000.
3. Second tick at cycle 10000. Required: byte 0x01 is sent and led = 6'b000001. After the sixth tick, byte 0x05 has been sent and led = 6'b000101.
4. Run 256 ticks. Required: tx_count wraps 0xFF→0x00; led[4:0] follows the low 5 bits and shows 0x1F then 0x00.
5. Assert reset mid-frame, 40 cycles after a start edge. Required: uart_tx_path=1 and led=0 immediately. After release, the sequence restarts at 0x00.
6. Break loopback and drive RX externally.
   - 8-cycle low glitch: no rx_valid.
   - Frame 0x15 with stop bit=0: rx_data is unchanged.
   - Valid frame 0x15: led[4:0] = 10101.

Source files
------------

// File: rtl/demo_pkg.sv
// Board-demo constants and the UART state encoding shared by the TX and RX machines.
// __SIM_CLK_DIV__ shrinks the tick period and bit time so simulations stay short.
package demo_pkg;
`ifdef __SIM_CLK_DIV__
  localparam int TICK_CYCLES = 5_000;
  localparam int BAUD_DIV    = 16;
`else
  localparam int TICK_CYCLES = 25_000_000;
  localparam int BAUD_DIV    = 434;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Bits needed for a counter running 0..n-1.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_8n1.sv
// 8N1 UART: byte transmitter with start/busy handshake, and a receiver that
// reports each correctly framed byte with a one-cycle rx_valid pulse.
module uart_8n1
  import demo_pkg::*;
#(
  parameter int BAUD_DIV = demo_pkg::BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_busy,
  output logic       tx_line,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid
);
  localparam int            BW        = cnt_width(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);

  uart_state_t   tx_state;
  logic [BW-1:0] tx_baud;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_baud_end;

  assign tx_baud_end = (tx_baud == BAUD_LAST);
  assign tx_busy     = (tx_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_line  <= 1'b1;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_baud <= (tx_state == IDLE || tx_baud_end) ? '0 : tx_baud + 1'b1;
      case (tx_state)
        IDLE: begin
          if (tx_start) begin
            tx_shift <= tx_byte;
            tx_line  <= 1'b0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_baud_end) begin
            tx_line  <= tx_shift[0];
            tx_bit   <= '0;
            tx_state <= DATA;
          end
        end
        DATA: begin
          if (tx_baud_end) begin
            if (tx_bit == 3'd7) begin
              tx_line  <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx_line  <= tx_shift[1];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 1'b1;
            end
          end
        end
        STOP: begin
          if (tx_baud_end) tx_state <= IDLE;
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  uart_state_t   rx_state;
  logic          rx_s1, rx_s2, rx_prev;
  logic [BW-1:0] rx_baud;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;

  // rx_prev holds the previous synchronized level so only a 1->0 transition starts a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_s1    <= rx_line;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      rx_baud  <= rx_baud + 1'b1;
      case (rx_state)
        IDLE: begin
          rx_baud <= '0;
          if (rx_prev && !rx_s2) rx_state <= START;
        end
        START: begin
          if (rx_baud == HALF_LAST) begin
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? IDLE : DATA;
          end
        end
        DATA: begin
          if (rx_baud == BAUD_LAST) begin
            rx_baud  <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end
        end
        STOP: begin
          if (rx_baud == BAUD_LAST) begin
            if (rx_s2) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end
            rx_state <= IDLE;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/demo_top.sv
// Board demo: a periodic tick sends an incrementing byte over the UART and the
// LEDs show a heartbeat plus the low bits of the last byte received.
module demo_top
  import demo_pkg::*;
#(
  parameter int TICK_CYCLES = demo_pkg::TICK_CYCLES,
  parameter int BAUD_DIV    = demo_pkg::BAUD_DIV
) (
  input  logic       clk_50m,
  input  logic       reset_n,
  output logic [5:0] led,
  output logic       uart_tx_path,
  input  logic       uart_rx_path
);
  localparam int            TW        = cnt_width(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          heartbeat;
  logic [7:0]    tx_count;
  logic          tx_busy;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [2:0]    rx_data_unused;

  assign tick           = (tick_cnt == TICK_LAST);
  assign rx_data_unused = rx_data[7:5];

  // reset_n is active-high on this board despite its name.
  always_ff @(posedge clk_50m or posedge reset_n) begin
    if (reset_n) begin
      tick_cnt  <= '0;
      heartbeat <= 1'b0;
      tx_count  <= '0;
      led       <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        heartbeat <= ~heartbeat;
        tx_count  <= tx_count + 8'd1;
      end
      led[5] <= heartbeat;
      if (rx_valid) led[4:0] <= rx_data[4:0];
    end
  end

  // A tick that finds the transmitter busy simply loses that count value.
  uart_8n1 #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clk     (clk_50m),
    .rst     (reset_n),
    .tx_start(tick && !tx_busy),
    .tx_byte (tx_count),
    .tx_busy (tx_busy),
    .tx_line (uart_tx_path),
    .rx_line (uart_rx_path),
    .rx_data (rx_data),
    .rx_valid(rx_valid)
  );
endmodule

// File: tb/tb_demo_top.sv
// Bench for demo_top: loopback frames checked bit by bit against the expected
// counter sequence, reset behaviour, and externally driven RX frames.
module tb_demo_top;
  localparam int TICK = 192;
  localparam int BAUD = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] led;
  logic       uart_tx_path;
  logic       uart_rx_path;
  logic       loopback;
  logic       rx_drv;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  assign uart_rx_path = loopback ? uart_tx_path : rx_drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  demo_top #(
    .TICK_CYCLES(TICK),
    .BAUD_DIV   (BAUD)
  ) dut (
    .clk_50m     (clk),
    .reset_n     (reset_n),
    .led         (led),
    .uart_tx_path(uart_tx_path),
    .uart_rx_path(uart_rx_path)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_fall(output int f);
    f = -1;
    for (int i = 0; i < TICK + 20 && f < 0; i++) begin
      @(negedge clk);
      if (uart_tx_path === 1'b0) f = cyc;
    end
    if (f < 0) begin
      chk("tx_start_seen", uart_tx_path, 1'b0);
      f = cyc;
    end
  endtask

  // Frame k after reset release carries k mod 256; the line drops one cycle after
  // the (k+1)-th tick, i.e. (k+1)*TICK cycles after release. The heartbeat has
  // toggled k+1 times by then.
  task automatic check_loop_frame(input int rel, input int k, input bit do_bits,
                                  input logic [4:0] prev_low);
    int         f;
    logic [7:0] b;
    logic [9:0] frame;
    logic       hb;
    b  = 8'(k);
    hb = ((k + 1) % 2) == 1;
    wait_fall(f);
    chk($sformatf("start_time_%0d", k), f - rel, (k + 1) * TICK);
    if (do_bits) begin
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
        wait_until(f + i * BAUD + BAUD / 2);
        chk($sformatf("tx_bit_%0d_%0d", k, i), uart_tx_path, frame[i]);
      end
    end
    wait_until(f + 9 * BAUD + 6);
    chk($sformatf("led_before_%0d", k), led, {hb, prev_low});
    wait_until(f + 10 * BAUD + 5);
    chk($sformatf("led_after_%0d", k), led, {hb, b[4:0]});
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = frame[i];
      repeat (BAUD) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation stalled at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int         f;
    int         off;
    int         rel;
    logic [7:0] b;
    logic       sb;
    logic [4:0] last_rx;

    loopback = 1'b1;
    rx_drv   = 1'b1;
    reset_n  = 1'b0;
    #2;
    reset_n  = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_led_early", led, 6'd0);
    chk("rst_tx_early", uart_tx_path, 1'b1);
    repeat ($urandom_range(30, 90)) @(negedge clk);
    chk("rst_led_late", led, 6'd0);
    chk("rst_tx_late", uart_tx_path, 1'b1);
    wait_until(100);
    reset_n = 1'b0;
    rel     = cyc;

    wait_until(rel + int'($urandom_range(5, TICK - 5)));
    chk("pre_tick_tx", uart_tx_path, 1'b1);
    chk("pre_tick_led", led, 6'd0);

    last_rx = 5'd0;
    for (int k = 0; k < 258; k++) begin
      check_loop_frame(rel, k, (k < 6) || (k[7:0] == 8'hFF) || (k >= 256), last_rx);
      last_rx = 5'(k);
    end

    for (int r = 0; r < 2; r++) begin
      wait_fall(f);
      off = (r == 0) ? 40 : int'($urandom_range(17, 150));
      wait_until(f + off);
      reset_n = 1'b1;
      #1;
      chk($sformatf("midrst_tx_%0d", r), uart_tx_path, 1'b1);
      chk($sformatf("midrst_led_%0d", r), led, 6'd0);
      repeat ($urandom_range(2, 20)) @(negedge clk);
      reset_n = 1'b0;
      rel     = cyc;
      check_loop_frame(rel, 0, 1'b1, 5'd0);
      check_loop_frame(rel, 1, 1'b0, 5'd0);
    end

    loopback = 1'b0;
    rx_drv   = 1'b1;
    last_rx  = 5'd1;
    repeat (BAUD) @(negedge clk);

    rx_drv = 1'b0;
    repeat (8) @(negedge clk);
    rx_drv = 1'b1;
    repeat (12 * BAUD) @(negedge clk);
    chk("rx_glitch8", led[4:0], last_rx);

    send_rx(8'h15, 1'b0);
    chk("rx_bad_stop_15", led[4:0], last_rx);
    send_rx(8'h15, 1'b1);
    last_rx = 5'h15;
    chk("rx_good_15", led[4:0], last_rx);

    for (int n = 0; n < 6; n++) begin
      rx_drv = 1'b0;
      repeat ($urandom_range(1, 7)) @(negedge clk);
      rx_drv = 1'b1;
      repeat (12 * BAUD) @(negedge clk);
      chk($sformatf("rx_glitch_rand_%0d", n), led[4:0], last_rx);
      b  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      send_rx(b, sb);
      if (sb) last_rx = b[4:0];
      chk($sformatf("rx_rand_%0d_stop%0d", n, sb), led[4:0], last_rx);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
